// File: rtl/signed_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : signed_arb_pkg
// Description : Shared state encoding and default widths for signed_add_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package signed_arb_pkg;

    localparam int W_DEF     = 4;
    localparam int N_REQ_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/signed_adder.sv
`default_nettype none
// ============================================================================
// Module      : signed_adder
// Description : Combinational two's-complement adder, W-bit operands, W+1-bit sum.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   sum
);

    // Sign-extend by one bit so the sum can never overflow.
    assign sum = {a[W-1], a} + {b[W-1], b};

endmodule
`default_nettype wire

// File: rtl/signed_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : signed_add_arbiter
// Description : Round-robin arbiter sharing one signed_adder among N_REQ requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_add_arbiter
    import signed_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] a_in,
    input  logic [N_REQ*W-1:0] b_in,
    output logic [N_REQ-1:0]   gnt,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [W:0]         res_sum,
    output logic [IDW-1:0]     res_id,
    output logic               busy
);

    localparam logic [N_REQ-1:0] c_gnt_lsb = N_REQ'(1);
    localparam logic [IDW-1:0]   c_last_id = IDW'(N_REQ - 1);

    state_t           r_state;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id_q;
    logic [W-1:0]     r_op_a;
    logic [W-1:0]     r_op_b;
    logic [N_REQ-1:0] r_gnt;
    logic             r_res_valid;
    logic [W:0]       r_res_sum;
    logic [IDW-1:0]   r_res_id;

    logic [IDW-1:0]   w_winner;
    logic [IDW-1:0]   w_ptr_next;
    logic [W:0]       w_sum;

    // First asserted request scanning upward from p, wrapping at N_REQ.
    function automatic logic [IDW-1:0] rr_pick(
        input logic [N_REQ-1:0] r,
        input logic [IDW-1:0]   p
    );
        logic [IDW-1:0] pick;
        logic           found;
        int             idx;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(p) + k) % N_REQ;
            if (!found && r[idx]) begin
                pick  = idx[IDW-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_winner   = rr_pick(req, r_ptr);
    assign w_ptr_next = (r_id_q == c_last_id) ? '0 : r_id_q + 1'b1;

    signed_adder #(
        .W (W)
    ) u_adder (
        .a   (r_op_a),
        .b   (r_op_b),
        .sum (w_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_id_q      <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_gnt       <= '0;
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
            r_res_id    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_op_a  <= a_in[w_winner*W +: W];
                        r_op_b  <= b_in[w_winner*W +: W];
                        r_gnt   <= c_gnt_lsb << w_winner;
                        r_id_q  <= w_winner;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_gnt       <= '0;
                    r_res_sum   <= w_sum;
                    r_res_valid <= 1'b1;
                    r_res_id    <= r_id_q;
                    r_state     <= RESP;
                end
                RESP: begin
                    // No bypass: a new grant always waits for the next IDLE cycle.
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_ptr       <= w_ptr_next;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign res_valid = r_res_valid;
    assign res_sum   = r_res_sum;
    assign res_id    = r_res_id;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire
